ebus_slice_arb: RTL

//  Parametrised EBUS data arbiter and transfer sequencer, successor to the fixed

---
 rtl/ebus_slice_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ebus_slice_arb.sv
// EBUS slice arbiter: per-slice driver arbitration onto a registered bus, sticky contention
// capture and a demand/xfer transfer sequencer. Slice 0 is the most significant slice (KL10 bit 0).
module ebus_slice_arb #(
    parameter int NDRV    = 24,
    parameter int NSLICE  = 6,
    parameter int SLICE_W = 6,
    parameter int TIMEOUT = 15,
    parameter int RR_MODE = 0
) (
    input  logic                        clk,
    input  logic                        crobar_l,
    input  logic [NDRV-1:0]             drv_driving,
    input  logic [NDRV*NSLICE-1:0]      drv_slice,
    input  logic [NDRV*NSLICE*SLICE_W-1:0] drv_data,
    input  logic                        demand,
    input  logic                        xfer,
    input  logic                        clr_err,
    output logic [NSLICE*SLICE_W-1:0]   ebus_data,
    output logic [NDRV*NSLICE-1:0]      grant,
    output logic [NSLICE*SLICE_W-1:0]   xfer_data,
    output logic                        xfer_done,
    output logic                        xfer_timeout,
    output logic                        busy,
    output logic                        contention_err,
    output logic [NSLICE-1:0]           err_slice
);
    localparam int DW = NSLICE * SLICE_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = (NDRV > 1) ? $clog2(NDRV) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, ACK, ABORT, HOLD} state_t;

    state_t state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          capture;

    logic [NSLICE-1:0][NDRV-1:0] req;
    logic [NSLICE-1:0][NDRV-1:0] win;
    logic [NSLICE-1:0][PW-1:0]   win_idx;
    logic [NSLICE-1:0][PW-1:0]   ptr;
    logic [NSLICE-1:0]           has_win;
    logic [NSLICE-1:0]           cont;
    logic [DW-1:0]               mux_data;

    // Search starts at ptr[s] in round-robin mode, at driver 0 otherwise.
    always_comb begin
        req      = '0;
        win      = '0;
        win_idx  = '0;
        has_win  = '0;
        cont     = '0;
        mux_data = '0;
        for (int s = 0; s < NSLICE; s++) begin
            for (int i = 0; i < NDRV; i++) begin
                req[s][i] = drv_driving[i] & drv_slice[i*NSLICE+s];
            end
            cont[s] = (req[s] & (req[s] - NDRV'(1))) != '0;
            for (int k = 0; k < NDRV; k++) begin
                int idx;
                idx = (RR_MODE != 0) ? (int'(ptr[s]) + k) % NDRV : k;
                if (!has_win[s] && req[s][idx]) begin
                    has_win[s] = 1'b1;
                    win_idx[s] = PW'(idx);
                end
            end
            if (has_win[s]) win[s][win_idx[s]] = 1'b1;
            for (int i = 0; i < NDRV; i++) begin
                mux_data[DW-1-s*SLICE_W -: SLICE_W] = mux_data[DW-1-s*SLICE_W -: SLICE_W]
                    | ({SLICE_W{win[s][i]}} & drv_data[i*DW + DW-1-s*SLICE_W -: SLICE_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge crobar_l) begin
        if (!crobar_l) begin
            ebus_data      <= '0;
            grant          <= '0;
            err_slice      <= '0;
            contention_err <= 1'b0;
            ptr            <= '0;
        end else begin
            ebus_data <= mux_data;
            for (int s = 0; s < NSLICE; s++) begin
                for (int i = 0; i < NDRV; i++) begin
                    grant[i*NSLICE+s] <= win[s][i];
                end
            end
            // New contention outranks a simultaneous clear.
            err_slice      <= (clr_err ? '0 : err_slice) | cont;
            contention_err <= (clr_err ? 1'b0 : contention_err) | (|cont);
            if (xfer_done) begin
                for (int s = 0; s < NSLICE; s++) begin
                    if (has_win[s]) begin
                        ptr[s] <= (win_idx[s] == PW'(NDRV-1)) ? '0 : win_idx[s] + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge crobar_l) begin
        if (!crobar_l) begin
            state     <= IDLE;
            cnt       <= '0;
            xfer_data <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (capture) xfer_data <= mux_data;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (demand) begin
                    next_state = WAIT;
                    next_cnt   = '0;
                end
            end
            WAIT: begin
                if (!demand) begin
                    next_state = IDLE;
                end else if (xfer) begin
                    next_state = ACK;
                    capture    = 1'b1;
                end else if (cnt == CW'(TIMEOUT-1)) begin
                    next_state = ABORT;
                end else if (cnt != '1) begin
                    next_cnt = cnt + CW'(1);
                end
            end
            ACK:     next_state = HOLD;
            ABORT:   next_state = HOLD;
            HOLD: begin
                if (!demand && !xfer) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pulses come straight from the one-cycle ACK/ABORT states.
    assign xfer_done    = (state == ACK);
    assign xfer_timeout = (state == ABORT);
    assign busy         = (state != IDLE);

endmodule
